// File: rtl/npu_load_ctrl.sv
// npu_load_ctrl: parses host ADDR/LEN/payload segments into an addressed payload stream for the control unit
module npu_load_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_valid_i,
    output logic                  h_ready_o,
    input  logic [DATA_WIDTH-1:0] h_data_i,
    input  logic                  abort_i,
    input  logic                  cu_ready_i,
    output logic                  sop_o,
    output logic                  valid_o,
    output logic                  eop_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [15:0]           word_cnt_o
);
    typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt, addr_nxt;
    logic [LEN_WIDTH-1:0] idx, idx_nxt, count, count_nxt, len_n;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [15:0] wc_nxt;
    logic last, last_nxt, sop_nxt, valid_nxt, eop_nxt, err_nxt, acc;
    assign h_ready_o = (state == IDLE) ? cu_ready_i && !abort_i : !abort_i;
    assign acc = h_valid_i && h_ready_o;
    assign busy_o = state != IDLE;
    assign len_n = h_data_i[LEN_WIDTH-1:0];
    always_comb begin
        state_nxt = state;
        base_nxt = base;
        idx_nxt = idx;
        count_nxt = count;
        last_nxt = last;
        sop_nxt = 1'b0;
        valid_nxt = 1'b0;
        eop_nxt = 1'b0;
        err_nxt = 1'b0;
        addr_nxt = addr_o;
        data_nxt = data_o;
        wc_nxt = word_cnt_o;
        if (state != IDLE && abort_i) begin
            state_nxt = IDLE;
            eop_nxt = 1'b1;
            err_nxt = 1'b1;
        end else if (acc) begin
            case (state)
                IDLE: begin
                    base_nxt = ADDR_WIDTH'(h_data_i);
                    state_nxt = LEN;
                    sop_nxt = 1'b1;
                    wc_nxt = 16'd0;
                end
                ADDR: begin
                    base_nxt = ADDR_WIDTH'(h_data_i);
                    state_nxt = LEN;
                end
                LEN: begin
                    last_nxt = h_data_i[15];
                    count_nxt = len_n;
                    idx_nxt = '0;
                    // an empty segment flags an error and ignores LAST
                    err_nxt = len_n == '0;
                    state_nxt = (len_n == '0) ? ADDR : DATA;
                end
                DATA: begin
                    valid_nxt = 1'b1;
                    data_nxt = h_data_i;
                    addr_nxt = base + ADDR_WIDTH'(idx);
                    idx_nxt = idx + LEN_WIDTH'(1);
                    wc_nxt = (word_cnt_o == 16'hFFFF) ? word_cnt_o : word_cnt_o + 16'd1;
                    if (idx == count - LEN_WIDTH'(1)) begin
                        state_nxt = last ? IDLE : ADDR;
                        eop_nxt = last;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base <= '0;
            idx <= '0;
            count <= '0;
            last <= 1'b0;
            sop_o <= 1'b0;
            valid_o <= 1'b0;
            eop_o <= 1'b0;
            err_o <= 1'b0;
            addr_o <= '0;
            data_o <= '0;
            word_cnt_o <= 16'd0;
        end else begin
            state <= state_nxt;
            base <= base_nxt;
            idx <= idx_nxt;
            count <= count_nxt;
            last <= last_nxt;
            sop_o <= sop_nxt;
            valid_o <= valid_nxt;
            eop_o <= eop_nxt;
            err_o <= err_nxt;
            addr_o <= addr_nxt;
            data_o <= data_nxt;
            word_cnt_o <= wc_nxt;
        end
    end
endmodule

// File: tb/tb_npu_load_ctrl.sv
// tb_npu_load_ctrl: directed vectors with hand-computed expectations for npu_load_ctrl
module tb_npu_load_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic h_valid_i = 1'b0;
    logic h_ready_o;
    logic [15:0] h_data_i = 16'h0;
    logic abort_i = 1'b0;
    logic cu_ready_i = 1'b0;
    logic sop_o, valid_o, eop_o, busy_o, err_o;
    logic [15:0] addr_o, data_o, word_cnt_o;
    int checks = 0;
    int errors = 0;
    npu_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .h_valid_i(h_valid_i), .h_ready_o(h_ready_o),
        .h_data_i(h_data_i), .abort_i(abort_i), .cu_ready_i(cu_ready_i),
        .sop_o(sop_o), .valid_o(valid_o), .eop_o(eop_o), .addr_o(addr_o),
        .data_o(data_o), .busy_o(busy_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // present one word and let the next edge accept it; results are visible on return
    task automatic send(input logic [15:0] w);
        h_valid_i = 1'b1;
        h_data_i = w;
        step();
    endtask
    task automatic beat(input string tag, input logic [15:0] a, input logic [15:0] d, input logic e);
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_addr"}, addr_o, a);
        check({tag, "_data"}, data_o, d);
        check({tag, "_eop"}, eop_o, e);
        check({tag, "_sop"}, sop_o, 0);
    endtask
    initial begin
        step();
        step();
        check("rst_busy", busy_o, 0);
        check("rst_flags", {sop_o, valid_o, eop_o, err_o}, 0);
        check("rst_addr", addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cnt", word_cnt_o, 0);
        rst_n = 1'b1;
        cu_ready_i = 1'b1;
        step();
        check("idle_ready", h_ready_o, 1);
        send(16'h0000);
        check("b_sop", sop_o, 1);
        check("b_sop_valid", valid_o, 0);
        check("b_busy", busy_o, 1);
        send(16'h8003);
        check("b_len_flags", {sop_o, valid_o}, 0);
        send(16'h1111);
        beat("b0", 16'h0000, 16'h1111, 0);
        send(16'h2222);
        beat("b1", 16'h0001, 16'h2222, 0);
        send(16'h3333);
        beat("b2", 16'h0002, 16'h3333, 1);
        check("b_cnt", word_cnt_o, 3);
        h_valid_i = 1'b0;
        step();
        check("b_idle", busy_o, 0);
        check("b_after_flags", {valid_o, eop_o}, 0);
        check("b_hold_addr", addr_o, 16'h0002);
        check("b_hold_data", data_o, 16'h3333);
        send(16'h0000);
        check("s_sop", sop_o, 1);
        check("s_cnt_clr", word_cnt_o, 0);
        send(16'h0002);
        send(16'hA0A0);
        beat("s0", 16'h0000, 16'hA0A0, 0);
        send(16'hA1A1);
        beat("s1", 16'h0001, 16'hA1A1, 0);
        send(16'h0100);
        check("s_addr_word", {sop_o, valid_o, eop_o}, 0);
        check("s_busy", busy_o, 1);
        send(16'h8001);
        send(16'h5050);
        beat("s2", 16'h0100, 16'h5050, 1);
        h_valid_i = 1'b0;
        cu_ready_i = 1'b0;
        step();
        h_valid_i = 1'b1;
        h_data_i = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            check("g_ready", h_ready_o, 0);
            step();
            check("g_sop", sop_o, 0);
            check("g_busy", busy_o, 0);
        end
        cu_ready_i = 1'b1;
        #1;
        check("g_ready_up", h_ready_o, 1);
        step();
        check("g_sop_up", sop_o, 1);
        send(16'h8000);
        check("e_err", err_o, 1);
        check("e_flags", {valid_o, eop_o}, 0);
        check("e_busy", busy_o, 1);
        h_valid_i = 1'b0;
        cu_ready_i = 1'b0;
        step();
        check("e_err_pulse", err_o, 0);
        check("e_still_busy", busy_o, 1);
        check("e_cu_ignored", h_ready_o, 1);
        send(16'h0010);
        send(16'h8001);
        send(16'hD00D);
        beat("e0", 16'h0010, 16'hD00D, 1);
        cu_ready_i = 1'b1;
        send(16'h0200);
        send(16'h8004);
        send(16'hC000);
        send(16'hC001);
        beat("a1", 16'h0201, 16'hC001, 0);
        abort_i = 1'b1;
        h_data_i = 16'hC002;
        #1;
        check("a_ready", h_ready_o, 0);
        step();
        check("a_eop", eop_o, 1);
        check("a_valid", valid_o, 0);
        check("a_err", err_o, 1);
        check("a_busy", busy_o, 0);
        check("a_cnt", word_cnt_o, 2);
        check("a_data_hold", data_o, 16'hC001);
        step();
        check("a_idle_abort_ready", h_ready_o, 0);
        check("a_idle_abort", {sop_o, eop_o, err_o, busy_o}, 0);
        abort_i = 1'b0;
        send(16'hFFFF);
        send(16'h8002);
        send(16'h7777);
        beat("w0", 16'hFFFF, 16'h7777, 0);
        h_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_stall_valid", valid_o, 0);
            check("w_stall_addr", addr_o, 16'hFFFF);
        end
        send(16'h8888);
        beat("w1", 16'h0000, 16'h8888, 1);
        check("w_cnt", word_cnt_o, 2);
        check("w_err", err_o, 0);
        send(16'h0300);
        send(16'h8003);
        send(16'h9999);
        h_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("r_async_busy", busy_o, 0);
        check("r_async_out", {addr_o, word_cnt_o}, 0);
        check("r_async_valid", valid_o, 0);
        step();
        check("r_no_eop", eop_o, 0);
        rst_n = 1'b1;
        send(16'h0000);
        check("r_resume_sop", sop_o, 1);
        h_valid_i = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
